miss_arbiter: RTL
=================

# miss_arbiter

- Shares the data-memory channels among the per-consumer miss/writeback request ports of the data cache.
- Each of NUM_CHANNELS channel engines does three things: grants one pending consumer request, drives it to memory, then relays the response back to that consumer.
- Sits between the data cache's controller-side ports and the memory interface.
- Reads and writebacks from up to NUM_CONSUMERS cache ports are multiplexed fairly onto fewer channels.

## Interface
- ADDR_BITS, 8, address width
- DATA_BITS, 8, data width
- NUM_CONSUMERS, 8, number of requester ports (cache miss ports)
- NUM_CHANNELS, 4, number of concurrent memory channels

Ports (array ports are NUM_CONSUMERS or NUM_CHANNELS entries, each of the listed width):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_read_valid  in  NUM_CONSUMERS  read request per consumer
- req_read_address  in  NUM_CONSUMERS x ADDR_BITS  read address
- req_read_ready  out  NUM_CONSUMERS  read response valid/ack
- req_read_data  out  NUM_CONSUMERS x DATA_BITS  read response data
- req_write_valid  in  NUM_CONSUMERS  writeback request
- req_write_address  in  NUM_CONSUMERS x ADDR_BITS  writeback address
- req_write_data  in  NUM_CONSUMERS x DATA_BITS  writeback data
- req_write_ready  out  NUM_CONSUMERS  writeback ack
- mem_read_valid  out  NUM_CHANNELS  memory read request
- mem_read_address  out  NUM_CHANNELS x ADDR_BITS
- mem_read_ready  in  NUM_CHANNELS  memory read done
- mem_read_data  in  NUM_CHANNELS x DATA_BITS
- mem_write_valid  out  NUM_CHANNELS  memory write request
- mem_write_address  out  NUM_CHANNELS x ADDR_BITS
- mem_write_data  out  NUM_CHANNELS x DATA_BITS
- mem_write_ready  in  NUM_CHANNELS  memory write done

## Operation

Per-channel FSM; the channel records an owner consumer index of width $clog2(NUM_CONSUMERS).
- IDLE
  - Candidate: a consumer with read or write valid, not owned by any channel, and not granted by a lower-indexed channel this cycle.
  - Scan starts at the priority pointer, wraps modulo NUM_CONSUMERS, and takes the first candidate.
  - If the candidate's write_valid is set, latch address/data and go to WRITE_WAITING; otherwise latch the address and go to READ_WAITING.
  - Write wins when a consumer asserts both valids.
- READ_WAITING: mem_read_valid=1 with the latched address. On mem_read_ready: latch data, drop mem_read_valid, set req_read_ready[owner]=1 and req_read_data[owner]=data, go to READ_RELAYING.
- WRITE_WAITING: mem_write_valid=1 with the latched address/data. On mem_write_ready: drop mem_write_valid, set req_write_ready[owner]=1, go to WRITE_RELAYING.
- READ_RELAYING / WRITE_RELAYING: hold ready (and data) until the owner's matching valid is sampled low. Then clear ready, release the owner, go to IDLE.

Other rules:
- A consumer is owned by at most one channel; there are no duplicate grants.
- Priority pointer: after any cycle with grants, it moves to (highest-indexed channel's granted consumer + 1) mod NUM_CONSUMERS.
- Request inputs are sampled only at grant; later changes are ignored until release.

## Timing
- Reset value of every output: 0. Pointer = 0, all channels IDLE, no owners.
- Request valid sampled at edge t while the channel is IDLE → mem_*_valid high from t+1.
- mem_*_ready sampled at edge u → mem valid low and req ready high from u+1.
- Owner valid sampled low at edge v → req ready low from v+1, channel IDLE at v+1. Earliest new grant on that channel is at edge v+1.
- When all channels are busy, requests wait with no loss; a waiting consumer sees ready=0.
- A read still valid after its consumer's write completes is granted as a new request.
- Reset mid-operation: everything returns to reset values at the next edge. Any in-flight memory response is dropped; memory must tolerate a valid being withdrawn.
- mem ready arriving in IDLE or RELAYING is ignored.

## Configuration
- MISS_ARB_RR_EN defined: the round-robin pointer operates as above.
- Undefined: the pointer is fixed at 0, giving fixed priority with the lowest consumer index first; no pointer register.

## Test plan
- Single read: consumer 3 reads 0x42, memory returns 0xA5 two cycles after mem_read_valid.
  - req_read_ready[3]=1 with data 0xA5 one cycle after mem_read_ready.
  - Ready clears one cycle after req_read_valid[3] drops.
- Contention: NUM_CHANNELS=2 and consumers 0,1,2 all read.
  - Channels 0/1 grant consumers 0/1; consumer 2 waits.
  - Consumer 2 is granted the cycle after the first channel returns to IDLE.
- Both valids on consumer 5 (write 0x10←0x77, read 0x20).
  - mem_write first, then req_write_ready[5].
  - After write_valid drops, the read to 0x20 is granted.
- Fairness (MISS_ARB_RR_EN): NUM_CHANNELS=1, all 8 consumers continuously requesting.
  - Grant order is 0,1,…,7,0.
  - Without the macro, consumer 0 is granted every time.
- Reset asserted during READ_WAITING: all outputs 0 the next cycle. A late mem_read_ready yields no req_read_ready.

Source files
------------

// File: rtl/miss_arbiter_if.sv
// Consumer miss/writeback ports plus per-channel memory ports of miss_arbiter.
// slave is the arbiter's view; master is the cache/memory environment's view.
interface miss_arbiter_if #(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CONSUMERS = 8,
   parameter int NUM_CHANNELS  = 4
);
   logic [NUM_CONSUMERS-1:0]                req_read_valid;
   logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] req_read_address;
   logic [NUM_CONSUMERS-1:0]                req_read_ready;
   logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] req_read_data;
   logic [NUM_CONSUMERS-1:0]                req_write_valid;
   logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] req_write_address;
   logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] req_write_data;
   logic [NUM_CONSUMERS-1:0]                req_write_ready;

   logic [NUM_CHANNELS-1:0]                 mem_read_valid;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address;
   logic [NUM_CHANNELS-1:0]                 mem_read_ready;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data;
   logic [NUM_CHANNELS-1:0]                 mem_write_valid;
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data;
   logic [NUM_CHANNELS-1:0]                 mem_write_ready;

   modport slave (
      input  req_read_valid, req_read_address, req_write_valid, req_write_address, req_write_data,
      output req_read_ready, req_read_data, req_write_ready,
      output mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
      input  mem_read_ready, mem_read_data, mem_write_ready
   );

   modport master (
      output req_read_valid, req_read_address, req_write_valid, req_write_address, req_write_data,
      input  req_read_ready, req_read_data, req_write_ready,
      input  mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
      output mem_read_ready, mem_read_data, mem_write_ready
   );
endinterface

// File: rtl/miss_arbiter.sv
// Shares NUM_CHANNELS memory channels among cache miss/writeback ports: 1 cycle grant->mem valid, 1 cycle mem ready->req ready;
// ungranted requests wait without loss. MISS_ARB_RR_EN enables the round-robin pointer, otherwise fixed priority from consumer 0.
module miss_arbiter #(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CONSUMERS = 8,
   parameter int NUM_CHANNELS  = 4
) (
   input  logic          clk,
   input  logic          reset,
   miss_arbiter_if.slave bus
);
   localparam int OWN_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

   typedef enum logic [2:0] {
      IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING
   } state_t;

   state_t                   state     [NUM_CHANNELS];
   state_t                   state_nxt [NUM_CHANNELS];
   logic [OWN_BITS-1:0]      owner     [NUM_CHANNELS];
   logic [ADDR_BITS-1:0]     addr_q    [NUM_CHANNELS];
   logic [DATA_BITS-1:0]     data_q    [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0]  grant_vld;
   logic [OWN_BITS-1:0]      grant_idx [NUM_CHANNELS];
   logic [NUM_CONSUMERS-1:0] owned;
   logic [NUM_CONSUMERS-1:0] avail;
   logic [OWN_BITS-1:0]      scan_idx;
   logic [OWN_BITS-1:0]      ptr;

`ifdef MISS_ARB_RR_EN
   logic [OWN_BITS-1:0]      ptr_nxt;

   // Highest-indexed granting channel wins, so later channels override earlier ones.
   always_comb begin
      ptr_nxt = ptr;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (grant_vld[c]) ptr_nxt = OWN_BITS'((int'(grant_idx[c]) + 1) % NUM_CONSUMERS);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) ptr <= '0;
      else       ptr <= ptr_nxt;
   end
`else
   assign ptr = '0;
`endif

   always_comb begin
      owned = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (state[c] != IDLE) owned[owner[c]] = 1'b1;
      end
   end

   // Channels grant in index order; each grant is removed from the pool seen by higher channels.
   always_comb begin
      avail     = (bus.req_read_valid | bus.req_write_valid) & ~owned;
      grant_vld = '0;
      scan_idx  = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         grant_idx[c] = '0;
         if (state[c] == IDLE) begin
            for (int k = 0; k < NUM_CONSUMERS; k++) begin
               scan_idx = OWN_BITS'((int'(ptr) + k) % NUM_CONSUMERS);
               if (!grant_vld[c] && avail[scan_idx]) begin
                  grant_vld[c] = 1'b1;
                  grant_idx[c] = scan_idx;
               end
            end
            if (grant_vld[c]) avail[grant_idx[c]] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (reset) begin
            state[c]  <= IDLE;
            owner[c]  <= '0;
            addr_q[c] <= '0;
            data_q[c] <= '0;
         end else begin
            state[c] <= state_nxt[c];
            if (grant_vld[c]) begin
               owner[c] <= grant_idx[c];
               if (bus.req_write_valid[grant_idx[c]]) begin
                  addr_q[c] <= bus.req_write_address[grant_idx[c]];
                  data_q[c] <= bus.req_write_data[grant_idx[c]];
               end else begin
                  addr_q[c] <= bus.req_read_address[grant_idx[c]];
               end
            end else if (state[c] == READ_WAITING && bus.mem_read_ready[c]) begin
               data_q[c] <= bus.mem_read_data[c];
            end
         end
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         state_nxt[c] = state[c];
         case (state[c])
            IDLE:           if (grant_vld[c])
                               state_nxt[c] = bus.req_write_valid[grant_idx[c]] ? WRITE_WAITING : READ_WAITING;
            READ_WAITING:   if (bus.mem_read_ready[c])  state_nxt[c] = READ_RELAYING;
            WRITE_WAITING:  if (bus.mem_write_ready[c]) state_nxt[c] = WRITE_RELAYING;
            READ_RELAYING:  if (!bus.req_read_valid[owner[c]])  state_nxt[c] = IDLE;
            WRITE_RELAYING: if (!bus.req_write_valid[owner[c]]) state_nxt[c] = IDLE;
            default:        state_nxt[c] = IDLE;
         endcase
      end
   end

   // Address/data outputs are zeroed whenever their qualifying valid/ready is low.
   always_comb begin
      bus.req_read_ready    = '0;
      bus.req_read_data     = '0;
      bus.req_write_ready   = '0;
      bus.mem_read_valid    = '0;
      bus.mem_read_address  = '0;
      bus.mem_write_valid   = '0;
      bus.mem_write_address = '0;
      bus.mem_write_data    = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         case (state[c])
            READ_WAITING: begin
               bus.mem_read_valid[c]   = 1'b1;
               bus.mem_read_address[c] = addr_q[c];
            end
            WRITE_WAITING: begin
               bus.mem_write_valid[c]   = 1'b1;
               bus.mem_write_address[c] = addr_q[c];
               bus.mem_write_data[c]    = data_q[c];
            end
            READ_RELAYING: begin
               bus.req_read_ready[owner[c]] = 1'b1;
               bus.req_read_data[owner[c]]  = data_q[c];
            end
            WRITE_RELAYING: bus.req_write_ready[owner[c]] = 1'b1;
            default: ;
         endcase
      end
   end
endmodule
